mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- Runtime writer that applies a clock configuration (master multiplier, master divisor, clock-0 divisor) to an MMCM through its Dynamic Reconfiguration Port (DRP).
- It is the applying end of our clock-mode configs: it holds the MMCM in reset, read-modify-writes five DRP registers, releases reset and waits for lock.
- Sits beside the clocking wrapper in the DRP clock domain.
- Integer ratios only; fractional settings are rejected.

Parameters:
- DRDY_TIMEOUT, 64: maximum cycles to wait for drp_drdy per access.
- LOCK_TIMEOUT, 100000: maximum cycles to wait for mmcm_locked after reset release.

Ports:
- clk  in  1  DRP clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- mult  in  7  CLKFBOUT multiplier; valid range 2..64.
- div  in  7  DIVCLK divisor; valid range 1..106.
- out_div  in  8  CLKOUT0 divisor; valid range 1..128.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  2  result code: 0 ok, 1 range, 2 drdy timeout, 3 lock timeout. Valid with done; held until the next start.
- drp_addr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_den  out  1  DRP enable, one-cycle strobe.
- drp_dwe  out  1  DRP write enable, asserted only together with drp_den.
- drp_drdy  in  1  DRP access complete.
- mmcm_rst  out  1  MMCM reset.
- mmcm_locked  in  1  MMCM lock, already synchronous to clk.

Behaviour:
- Reset values: busy, done, drp_den, drp_dwe, mmcm_rst = 0; err, drp_addr, drp_di = 0; FSM in IDLE.
- Asserting rst mid-sequence aborts immediately and releases mmcm_rst. The MMCM may then be left partially written; software must rerun the sequence.
- start in IDLE: mult, div and out_div are latched; FSM moves to CHECK.
- start while busy is ignored. Inputs are don't-care outside the start cycle.
- CHECK:
  - Any value out of range sets err=1, pulses done the next cycle and returns to IDLE.
  - In this case there is no DRP activity and mmcm_rst is never asserted.
- ASSERT_RST: mmcm_rst=1; mmcm_rst stays high through all DRP accesses.
- Register list, processed in order 0x08, 0x09, 0x14, 0x15, 0x16. Per register: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT.
- RD_REQ:
  - drp_den=1 for exactly one cycle with drp_addr set and drp_dwe=0.
  - RD_WAIT captures drp_do on the drp_drdy cycle.
- WR_REQ:
  - drp_den=1 and drp_dwe=1 for one cycle.
  - drp_di = (captured & keep_mask) | new_bits.
  - WR_WAIT waits for drp_drdy.
- drp_addr is held stable from the request until drdy.
- Divider encoding, for D = out_div (regs 0x08/0x09), mult (0x14/0x15), div (0x16):
  - high = D>>1, low = D-high, edge = D[0].
  - D=1: high=1, low=1, no_count=1.
  - A value of 64 is encoded as 0 in the 6-bit fields.
- Register fields:
  - 0x08 / 0x14: keep [15:12]; [11:6]=high, [5:0]=low.
  - 0x09 / 0x15: keep [15:8]; [7]=edge, [6]=no_count, [5:0]=0 (delay cleared).
  - 0x16: keep [15:14]; [13]=edge, [12]=no_count, [11:6]=high, [5:0]=low.
- Lock and filter registers are not rewritten.
- drdy timeout: if DRDY_TIMEOUT cycles pass in RD_WAIT or WR_WAIT without drdy, err=2 and done pulses. mmcm_rst stays 1 (configuration is incomplete) until the next start or rst.
- RELEASE: mmcm_rst=0.
- WAIT_LOCK:
  - mmcm_locked high ends the wait with err=0 and a done pulse.
  - After LOCK_TIMEOUT cycles without lock: err=3 and done pulses.
  - mmcm_locked is ignored during the first 2 cycles after release to avoid stale lock.
- Timeout counters restart for every access and for the lock wait.
- done and busy: done pulses exactly one cycle; busy falls in the same cycle done rises; IDLE follows.

Test Plan:
- DRP model preloaded with 0xFFFF, locked returns 20 cycles after release; mult=6, div=1, out_div=6 -> writes 0x08=0xF0C3, 0x09=0xFF00, 0x14=0xF0C3, 0x15=0xFF00, 0x16=0xD041; done with err=0; exactly 5 reads and 5 writes.
- out_div=15 (mult=6, div=1) -> 0x08=0xF1C8, 0x09=0xFF80. out_div=128 -> 0x08=0xF000, 0x09=0xFF00.
- mult=1 or out_div=0 -> err=1; done 2 cycles after start; drp_den and mmcm_rst never asserted.
- DRP model withholds drdy on address 0x14 -> err=2 after 64 cycles; mmcm_rst remains 1; no access to 0x15 or 0x16.
- mmcm_locked held low -> err=3 after LOCK_TIMEOUT cycles; mmcm_rst=0.
- Second start pulsed mid-sequence -> ignored, and no extra DRP accesses occur. rst asserted while in WR_WAIT -> all outputs return to 0 asynchronously, and a new start runs the full sequence correctly.

Source files
------------

// File: rtl/mmcm_drp_reconfig.sv
// -----------------------------------------------------------------------------
// mmcm_drp_reconfig
//
// Applies an integer clock configuration (CLKFBOUT multiplier, DIVCLK divisor,
// CLKOUT0 divisor) to an MMCM over its DRP. The MMCM is held in reset, five DRP
// registers are read-modify-written, reset is released and lock is awaited.
//
// Ports
//   clk, rst          DRP clock, asynchronous active-high reset
//   start             single-cycle request, accepted only when idle
//   mult/div/out_div  configuration, latched on an accepted start
//   busy, done, err   status; err: 0 ok, 1 range, 2 drdy timeout, 3 lock timeout
//   drp_*             DRP master (addr, di, do, den, dwe, drdy)
//   mmcm_rst          MMCM reset
//   mmcm_locked       MMCM lock, already synchronous to clk
// -----------------------------------------------------------------------------
module mmcm_drp_reconfig #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  mult,
    input  logic [6:0]  div,
    input  logic [7:0]  out_div,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [6:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam logic [31:0] DRDY_LAST = 32'(DRDY_TIMEOUT - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_ASSERT_RST, S_RD_REQ, S_RD_WAIT,
        S_WR_REQ, S_WR_WAIT, S_NEXT, S_RELEASE, S_WAIT_LOCK
    } state_t;

    // Divider fields packed as {edge, no_count, high[5:0], low[5:0]}.
    // A divide of 1 bypasses the counter: edge must be 0 there, not d[0].
    // 64 wraps to 0 in the 6-bit fields, which is the MMCM encoding for 64.
    function automatic logic [13:0] div_enc(input logic [7:0] d);
        if (d == 8'd1)
            return {1'b0, 1'b1, 6'd1, 6'd1};
        return {d[0], 1'b0, d[6:1], 6'(d - {1'b0, d[7:1]})};
    endfunction

    function automatic logic [6:0] reg_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return 7'h08;
            3'd1:    return 7'h09;
            3'd2:    return 7'h14;
            3'd3:    return 7'h15;
            default: return 7'h16;
        endcase
    endfunction

    // Merge new divider fields into the value read back; unrelated bits
    // (phase mux, delay high bits, lock/filter settings) are preserved.
    function automatic logic [15:0] reg_value(input logic [2:0]  idx,
                                              input logic [15:0] cur,
                                              input logic [13:0] e_out,
                                              input logic [13:0] e_mult,
                                              input logic [13:0] e_div);
        case (idx)
            3'd0:    return (cur & 16'hF000) | {4'b0, e_out[11:0]};
            3'd1:    return (cur & 16'hFF00) | {8'b0, e_out[13:12], 6'b0};
            3'd2:    return (cur & 16'hF000) | {4'b0, e_mult[11:0]};
            3'd3:    return (cur & 16'hFF00) | {8'b0, e_mult[13:12], 6'b0};
            default: return (cur & 16'hC000) | {2'b0, e_div};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] di_q, di_d;
    logic        mrst_q, mrst_d;
    logic        load;

    logic [6:0]  mult_q, div_q;
    logic [7:0]  out_div_q;
    logic        in_range;
    logic [13:0] enc_out, enc_mult, enc_div;

    assign in_range = (mult_q >= 7'd2) && (mult_q <= 7'd64) &&
                      (div_q >= 7'd1) && (div_q <= 7'd106) &&
                      (out_div_q >= 8'd1) && (out_div_q <= 8'd128);

    assign enc_out  = div_enc(out_div_q);
    assign enc_mult = div_enc({1'b0, mult_q});
    assign enc_div  = div_enc({1'b0, div_q});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        di_d    = di_q;
        mrst_d  = mrst_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    err_d   = 2'd0;
                    mrst_d  = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!in_range) begin
                    err_d   = 2'd1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mrst_d  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: begin
                addr_d  = reg_addr(idx_q);
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                cnt_d   = 32'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    di_d    = reg_value(idx_q, drp_do, enc_out, enc_mult, enc_div);
                    state_d = S_WR_REQ;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 2'd2;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WR_REQ: begin
                cnt_d   = 32'd0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    state_d = S_NEXT;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 2'd2;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_NEXT: begin
                if (idx_q == 3'd4) begin
                    mrst_d  = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    addr_d  = reg_addr(idx_q + 3'd1);
                    state_d = S_RD_REQ;
                end
            end
            S_RELEASE: begin
                cnt_d   = 32'd0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock is ignored for the first two wait cycles so that a
                // lock indication left over from before reset is not trusted.
                if (mmcm_locked && (cnt_q >= 32'd2)) begin
                    err_d   = 2'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    err_d   = 2'd3;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
            addr_q  <= 7'd0;
            di_q    <= 16'd0;
            mrst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            mrst_q  <= mrst_d;
        end
    end

    // Configuration is only meaningful after a start, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            mult_q    <= mult;
            div_q     <= div;
            out_div_q <= out_div;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign drp_addr = addr_q;
    assign drp_di   = di_q;
    assign drp_den  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign drp_dwe  = (state_q == S_WR_REQ);
    assign mmcm_rst = mrst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
module tb_mmcm_drp_reconfig;

    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 300;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [6:0]  mult, div;
    logic [7:0]  out_div;
    logic        busy, done;
    logic [1:0]  err;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di, drp_do;
    logic        drp_den, drp_dwe, drp_drdy;
    logic        mmcm_rst, mmcm_locked;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(.DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mult(mult), .div(div), .out_div(out_div),
        .busy(busy), .done(done), .err(err), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_drdy(drp_drdy),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    int errors = 0;
    int checks = 0;

    // DRP / MMCM model controls (driven by the test sequence)
    logic       withhold_en   = 1'b0;
    logic [6:0] withhold_addr = 7'h14;
    logic       lock_hold_low = 1'b0;

    // DRP / MMCM model state (written only by the model process)
    logic [15:0] mem [0:127];
    logic [6:0]  acc_addr [0:511];
    logic        acc_we   [0:511];
    int acc_n = 0, rd_cnt = 0, wr_cnt = 0, proto_err = 0, cyc = 0, mrst_cyc = 0;
    int den14_cyc = 0, rel_cyc = 0, lock_cnt = 0, dly = 0;
    logic       pend = 1'b0, prev_mrst = 1'b0;
    logic [6:0] pend_addr = 7'd0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mmcm_rst) mrst_cyc = mrst_cyc + 1;
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
            pend = 1'b0; lock_cnt = 0; prev_mrst = 1'b0;
            drp_drdy <= 1'b0; drp_do <= 16'h0; mmcm_locked <= 1'b0;
        end else begin
            drp_drdy <= 1'b0;
            if (drp_dwe && !drp_den) proto_err = proto_err + 1;
            if (drp_den) begin
                if (pend) proto_err = proto_err + 1;
                if (acc_n < 512) begin
                    acc_addr[acc_n] = drp_addr; acc_we[acc_n] = drp_dwe; acc_n = acc_n + 1;
                end
                if (drp_dwe) begin mem[drp_addr] = drp_di; wr_cnt = wr_cnt + 1; end
                else rd_cnt = rd_cnt + 1;
                if (drp_addr == 7'h14 && !drp_dwe) den14_cyc = cyc;
                if (!(withhold_en && drp_addr == withhold_addr)) begin
                    pend = 1'b1; pend_addr = drp_addr; dly = 1;
                end
            end else if (pend) begin
                if (drp_addr != pend_addr) proto_err = proto_err + 1;
                if (dly != 0) dly = dly - 1;
                else begin drp_drdy <= 1'b1; drp_do <= mem[pend_addr]; pend = 1'b0; end
            end
            if (mmcm_rst) begin
                lock_cnt = 0; mmcm_locked <= 1'b0;
            end else begin
                if (prev_mrst) rel_cyc = cyc;
                if (!lock_hold_low) begin
                    if (lock_cnt < 19) lock_cnt = lock_cnt + 1;
                    else mmcm_locked <= 1'b1;
                end
            end
            prev_mrst = mmcm_rst;
        end
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [6:0] m, input logic [6:0] d, input logic [7:0] o);
        @(negedge clk);
        start = 1'b1; mult = m; div = d; out_div = o;
        @(negedge clk);
        start = 1'b0; mult = 7'h55; div = 7'h7F; out_div = 8'hEE;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mult = 7'd0; div = 7'd0; out_div = 8'd0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (err !== 2'd0) begin errors++; $display("FAIL rst_err got=%0d exp=0", err); end
        checks++; if ({drp_den, drp_dwe, mmcm_rst} !== 3'b000) begin errors++; $display("FAIL rst_ctl got=%b exp=000", {drp_den, drp_dwe, mmcm_rst}); end
        checks++; if ({drp_addr, drp_di} !== 23'd0) begin errors++; $display("FAIL rst_addr_di got=%h/%h exp=0/0", drp_addr, drp_di); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int rd0, wr0, pe0, base;
        bit seen, ok;
        logic [6:0] ea [10] = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h14, 7'h14, 7'h15, 7'h15, 7'h16, 7'h16};
        do_reset();
        rd0 = rd_cnt; wr0 = wr_cnt; pe0 = proto_err; base = acc_n;
        pulse_start(7'd6, 7'd1, 8'd6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_after_start got=%b exp=1", busy); end
        wait_done(1000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL nom_done_timeout got=none exp=done"); end
        checks++; if (err !== 2'd0) begin errors++; $display("FAIL nom_err got=%0d exp=0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_at_done got=%b exp=0", busy); end
        checks++; if (mmcm_rst !== 1'b0) begin errors++; $display("FAIL nom_mmcm_rst got=%b exp=0", mmcm_rst); end
        checks++; if (mem[7'h08] !== 16'hF0C3) begin errors++; $display("FAIL nom_r08 got=%h exp=f0c3", mem[7'h08]); end
        checks++; if (mem[7'h09] !== 16'hFF00) begin errors++; $display("FAIL nom_r09 got=%h exp=ff00", mem[7'h09]); end
        checks++; if (mem[7'h14] !== 16'hF0C3) begin errors++; $display("FAIL nom_r14 got=%h exp=f0c3", mem[7'h14]); end
        checks++; if (mem[7'h15] !== 16'hFF00) begin errors++; $display("FAIL nom_r15 got=%h exp=ff00", mem[7'h15]); end
        checks++; if (mem[7'h16] !== 16'hD041) begin errors++; $display("FAIL nom_r16 got=%h exp=d041", mem[7'h16]); end
        checks++; if (rd_cnt - rd0 != 5) begin errors++; $display("FAIL nom_reads got=%0d exp=5", rd_cnt - rd0); end
        checks++; if (wr_cnt - wr0 != 5) begin errors++; $display("FAIL nom_writes got=%0d exp=5", wr_cnt - wr0); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
            if (acc_addr[base+i] !== ea[i] || acc_we[base+i] !== i[0]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL nom_order got=out_of_order exp=rd/wr 08,09,14,15,16"); end
        checks++; if (proto_err != pe0) begin errors++; $display("FAIL nom_protocol got=%0d exp=0", proto_err - pe0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_width got=%b exp=0", done); end
    endtask

    task automatic test_out_div();
        logic [7:0]  vo  [2] = '{8'd15, 8'd128};
        logic [15:0] e08 [2] = '{16'hF1C8, 16'hF000};
        logic [15:0] e09 [2] = '{16'hFF80, 16'hFF00};
        bit seen;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            pulse_start(7'd6, 7'd1, vo[v]);
            wait_done(1000, seen);
            checks++; if (!seen || err !== 2'd0) begin errors++; $display("FAIL od%0d_done got=%b/%0d exp=1/0", vo[v], seen, err); end
            checks++; if (mem[7'h08] !== e08[v]) begin errors++; $display("FAIL od%0d_r08 got=%h exp=%h", vo[v], mem[7'h08], e08[v]); end
            checks++; if (mem[7'h09] !== e09[v]) begin errors++; $display("FAIL od%0d_r09 got=%h exp=%h", vo[v], mem[7'h09], e09[v]); end
            checks++; if (mem[7'h14] !== 16'hF0C3) begin errors++; $display("FAIL od%0d_r14 got=%h exp=f0c3", vo[v], mem[7'h14]); end
        end
    endtask

    task automatic test_range();
        logic [6:0] vm [5] = '{7'd1, 7'd6, 7'd6, 7'd65, 7'd6};
        logic [6:0] vd [5] = '{7'd1, 7'd1, 7'd107, 7'd1, 7'd0};
        logic [7:0] vo [5] = '{8'd6, 8'd0, 8'd6, 8'd6, 8'd129};
        int a0, m0;
        for (int v = 0; v < 5; v++) begin
            a0 = acc_n; m0 = mrst_cyc;
            pulse_start(vm[v], vd[v], vo[v]);
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rng%0d_check_cycle got=busy%b/done%b exp=1/0", v, busy, done); end
            @(negedge clk);
            checks++; if (done !== 1'b1 || err !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL rng%0d_done got=done%b/err%0d/busy%b exp=1/1/0", v, done, err, busy); end
            repeat (3) @(negedge clk);
            checks++; if (err !== 2'd1 || done !== 1'b0) begin errors++; $display("FAIL rng%0d_hold got=err%0d/done%b exp=1/0", v, err, done); end
            checks++; if (acc_n != a0 || mrst_cyc != m0) begin errors++; $display("FAIL rng%0d_quiet got=acc%0d/rst%0d exp=0/0", v, acc_n - a0, mrst_cyc - m0); end
        end
    endtask

    task automatic test_drdy_timeout();
        int base, dt;
        bit seen, ok;
        do_reset();
        withhold_en = 1'b1; withhold_addr = 7'h14;
        base = acc_n;
        pulse_start(7'd6, 7'd1, 8'd6);
        wait_done(1000, seen);
        dt = cyc - den14_cyc;
        checks++; if (!seen || err !== 2'd2) begin errors++; $display("FAIL to_err got=%b/%0d exp=1/2", seen, err); end
        checks++; if (dt < DRDY_TO - 1 || dt > DRDY_TO + 2) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", dt, DRDY_TO); end
        checks++; if (mmcm_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_rst_busy got=%b/%b exp=1/0", mmcm_rst, busy); end
        ok = 1'b1;
        for (int i = base; i < acc_n; i++) if (acc_addr[i] == 7'h15 || acc_addr[i] == 7'h16) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL to_no_15_16 got=accessed exp=none"); end
        repeat (5) @(negedge clk);
        checks++; if (mmcm_rst !== 1'b1 || err !== 2'd2) begin errors++; $display("FAIL to_hold got=%b/%0d exp=1/2", mmcm_rst, err); end
        withhold_en = 1'b0;
        pulse_start(7'd1, 7'd1, 8'd6);
        checks++; if (mmcm_rst !== 1'b0 || err !== 2'd0) begin errors++; $display("FAIL to_restart got=%b/%0d exp=0/0", mmcm_rst, err); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 2'd1) begin errors++; $display("FAIL to_restart_rng got=%b/%0d exp=1/1", done, err); end
    endtask

    task automatic test_lock_timeout();
        int wr0, dt;
        bit seen;
        do_reset();
        lock_hold_low = 1'b1;
        wr0 = wr_cnt;
        pulse_start(7'd6, 7'd1, 8'd6);
        wait_done(2000, seen);
        dt = cyc - rel_cyc;
        checks++; if (!seen || err !== 2'd3) begin errors++; $display("FAIL lock_err got=%b/%0d exp=1/3", seen, err); end
        checks++; if (dt < LOCK_TO - 1 || dt > LOCK_TO + 3) begin errors++; $display("FAIL lock_latency got=%0d exp=%0d", dt, LOCK_TO); end
        checks++; if (mmcm_rst !== 1'b0 || wr_cnt - wr0 != 5) begin errors++; $display("FAIL lock_state got=%b/%0d exp=0/5", mmcm_rst, wr_cnt - wr0); end
        lock_hold_low = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rd0, wr0, a0;
        bit seen;
        do_reset();
        rd0 = rd_cnt; wr0 = wr_cnt;
        pulse_start(7'd6, 7'd1, 8'd6);
        repeat (15) @(negedge clk);
        pulse_start(7'd10, 7'd2, 8'd20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        wait_done(1000, seen);
        checks++; if (!seen || err !== 2'd0) begin errors++; $display("FAIL b2b_done got=%b/%0d exp=1/0", seen, err); end
        checks++; if (mem[7'h14] !== 16'hF0C3 || mem[7'h16] !== 16'hD041) begin errors++; $display("FAIL b2b_values got=%h/%h exp=f0c3/d041", mem[7'h14], mem[7'h16]); end
        a0 = acc_n;
        repeat (40) @(negedge clk);
        checks++; if (rd_cnt - rd0 != 5 || wr_cnt - wr0 != 5 || acc_n != a0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_accesses got=%0d/%0d exp=5/5", rd_cnt - rd0, wr_cnt - wr0); end
    endtask

    task automatic test_rst_abort();
        int wr0;
        bit seen;
        do_reset();
        pulse_start(7'd6, 7'd1, 8'd6);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drp_den && drp_dwe) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_no_write got=none exp=write"); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, drp_den, drp_dwe, mmcm_rst} !== 5'b0) begin errors++; $display("FAIL abort_ctl got=%b exp=00000", {busy, done, drp_den, drp_dwe, mmcm_rst}); end
        checks++; if ({err, drp_addr, drp_di} !== 25'd0) begin errors++; $display("FAIL abort_data got=%0d/%h/%h exp=0/0/0", err, drp_addr, drp_di); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr0 = wr_cnt;
        pulse_start(7'd6, 7'd1, 8'd15);
        wait_done(1000, seen);
        checks++; if (!seen || err !== 2'd0 || wr_cnt - wr0 != 5) begin errors++; $display("FAIL rerun_done got=%b/%0d/%0d exp=1/0/5", seen, err, wr_cnt - wr0); end
        checks++; if (mem[7'h08] !== 16'hF1C8 || mem[7'h09] !== 16'hFF80 || mem[7'h16] !== 16'hD041) begin errors++; $display("FAIL rerun_values got=%h/%h/%h exp=f1c8/ff80/d041", mem[7'h08], mem[7'h09], mem[7'h16]); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_out_div();
        test_range();
        test_drdy_timeout();
        test_lock_timeout();
        test_back_to_back();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=stalled exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
